// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter for the shared line-wide memory port.
// The grant is held until the owner's captured read/write complete; a watchdog flags long grants.
module mem_arbiter2 #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 128,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   m0_raddr,
  input  logic                    m0_ren,
  output logic [LINE_WIDTH-1:0]   m0_rdata,
  output logic                    m0_rvalid,
  input  logic [ADDR_WIDTH-1:0]   m0_waddr,
  input  logic                    m0_wen,
  input  logic [LINE_WIDTH-1:0]   m0_wdata,
  input  logic [LINE_WIDTH/8-1:0] m0_wmask,
  output logic                    m0_wvalid,
  input  logic [ADDR_WIDTH-1:0]   m1_raddr,
  input  logic                    m1_ren,
  output logic [LINE_WIDTH-1:0]   m1_rdata,
  output logic                    m1_rvalid,
  input  logic [ADDR_WIDTH-1:0]   m1_waddr,
  input  logic                    m1_wen,
  input  logic [LINE_WIDTH-1:0]   m1_wdata,
  input  logic [LINE_WIDTH/8-1:0] m1_wmask,
  output logic                    m1_wvalid,
  output logic [ADDR_WIDTH-1:0]   s_raddr,
  output logic                    s_ren,
  output logic [ADDR_WIDTH-1:0]   s_waddr,
  output logic                    s_wen,
  output logic [LINE_WIDTH-1:0]   s_wdata,
  output logic [LINE_WIDTH/8-1:0] s_wmask,
  input  logic [LINE_WIDTH-1:0]   s_rdata,
  input  logic                    s_rvalid,
  input  logic                    s_wvalid,
  output logic [1:0]              grant,
  output logic                    err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  // State codes double as the one-hot grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0]      state, state_nxt;
  logic            last;
  logic            pend_r, pend_w;
  logic            err_q;
  logic [WD_W-1:0] wdog;

  logic sel0, sel1;
  logic own_ren, own_wen;
  logic req0, req1;
  logic rdone, wdone;

  assign sel0    = (state == GNT0);
  assign sel1    = (state == GNT1);
  assign own_ren = (sel0 & m0_ren) | (sel1 & m1_ren);
  assign own_wen = (sel0 & m0_wen) | (sel1 & m1_wen);
  assign req0    = m0_ren | m0_wen;
  assign req1    = m1_ren | m1_wen;
  assign rdone   = s_rvalid & pend_r;
  assign wdone   = s_wvalid & pend_w;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // last==1 means master 0 has priority on a tie.
        if (req0 && (!req1 || last))
          state_nxt = GNT0;
        else if (req1)
          state_nxt = GNT1;
      end
      default: begin
        if (!(own_ren || own_wen))
          state_nxt = IDLE;
        else if (!(pend_r && !rdone) && !(pend_w && !wdone))
          state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      last   <= 1'b1;
      pend_r <= 1'b0;
      pend_w <= 1'b0;
      wdog   <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        wdog <= '0;
        if (state_nxt == GNT0) begin
          last   <= 1'b0;
          pend_r <= m0_ren;
          pend_w <= m0_wen;
        end else if (state_nxt == GNT1) begin
          last   <= 1'b1;
          pend_r <= m1_ren;
          pend_w <= m1_wen;
        end
      end else begin
        if (state_nxt == IDLE) begin
          pend_r <= 1'b0;
          pend_w <= 1'b0;
        end else begin
          pend_r <= pend_r & ~rdone;
          pend_w <= pend_w & ~wdone;
        end
        if (wdog != WD_MAX)
          wdog <= wdog + 1'b1;
        if (wdog == WD_MAX - 1'b1)
          err_q <= 1'b1;
      end
    end
  end

  assign grant       = state;
  assign err_timeout = err_q;

  // Only the owner's request lines reach memory, and only for captured operations.
  assign s_raddr = sel0 ? m0_raddr : (sel1 ? m1_raddr : '0);
  assign s_waddr = sel0 ? m0_waddr : (sel1 ? m1_waddr : '0);
  assign s_wdata = sel0 ? m0_wdata : (sel1 ? m1_wdata : '0);
  assign s_wmask = sel0 ? m0_wmask : (sel1 ? m1_wmask : '0);
  assign s_ren   = own_ren & pend_r;
  assign s_wen   = own_wen & pend_w;

  assign m0_rdata  = sel0 ? s_rdata : '0;
  assign m1_rdata  = sel1 ? s_rdata : '0;
  assign m0_rvalid = sel0 & rdone;
  assign m1_rvalid = sel1 & rdone;
  assign m0_wvalid = sel0 & wdone;
  assign m1_wvalid = sel1 & wdone;

endmodule
